bit_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder built around the team's existing 1-bit full_adder cell.
- Processes one bit per clock, LSB first. A registered carry flip-flop feeds each bit's carry-out back as the next bit's carry-in.
- Intended as the sequential stage in front of the cell, for area-constrained datapaths that trade latency for a single adder bit.
- Uses a start/busy/done handshake toward the requesting controller.

---
 rtl/bit_serial_adder_pkg.sv | 14 +
 rtl/bit_serial_adder_full_adder.sv | 19 +
 rtl/bit_serial_adder.sv | 128 ++++++++++++
 tb/tb_bit_serial_adder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder slice.
//   DEFAULT_WIDTH : default operand/result width
//   state_e       : controller states (IDLE / RUN / DONE)
package bit_serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// Combinational 1-bit full adder cell.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one bit per clock, LSB first, using a single
// full_adder cell and a registered carry.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request pulse, accepted in IDLE or DONE
//   a, b  : operands, sampled on the accepting edge
//   cin   : carry in, sampled on the accepting edge
//   busy  : high while an addition is in progress (WIDTH cycles)
//   done  : one-cycle pulse when sum/cout are updated
//   sum   : registered result (mod 2^WIDTH)
//   cout  : registered final carry out
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned       CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;
   logic [WIDTH-1:0]   sb_q, sb_d;
   logic [WIDTH-1:0]   ss_q, ss_d;
   logic               c_q, c_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               fa_s;
   logic               fa_co;

   full_adder u_fa (
      .a  (sa_q[0]),
      .b  (sb_q[0]),
      .ci (c_q),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      ss_d    = ss_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               c_d     = cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
            ss_d  = {fa_s, ss_q[WIDTH-1:1]};
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            c_d   = fa_co;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               sum_d   = {fa_s, ss_q[WIDTH-1:1]};
               cout_d  = fa_co;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Status flags are registered copies of the next state.
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         ss_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ss_q    <= ss_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

   localparam int unsigned W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      start = 1'b1;
      a     = av;
      b     = bv;
      cin   = cv;
   endtask

   // Returns at the negedge following the accepting edge (RUN cycle 1).
   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      @(negedge clk);
      drive(av, bv, cv);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts busy cycles (bounded), checks result hold during RUN, then the
   // done-cycle outputs. Optionally pulses a stray start at RUN cycle inject_at+1.
   task automatic wait_result(input logic [W-1:0] es, input logic ec,
                              input logic [W-1:0] ps, input logic pc,
                              input int inject_at);
      int n;
      n = 0;
      for (int k = 0; k < 20 && busy === 1'b1; k++) begin
         check("done_low_in_run", 32'(done), 32'd0);
         check("sum_held", 32'(sum), 32'(ps));
         check("cout_held", 32'(cout), 32'(pc));
         if (k == inject_at) drive(8'h01, 8'h01, 1'b0);
         else start = 1'b0;
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_cycles", 32'(n), 32'(W));
      check("done_pulse", 32'(done), 32'd1);
      check("sum", 32'(sum), 32'(es));
      check("cout", 32'(cout), 32'(ec));
   endtask

   task automatic idle_after();
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      launch(8'h5A, 8'h3C, 1'b0);
      wait_result(8'h96, 1'b0, 8'h00, 1'b0, -1);
      idle_after();

      launch(8'hFF, 8'h01, 1'b0);
      wait_result(8'h00, 1'b1, 8'h96, 1'b0, -1);
      idle_after();

      launch(8'hFF, 8'hFF, 1'b1);
      wait_result(8'hFF, 1'b1, 8'h00, 1'b1, -1);
      idle_after();

      launch(8'h00, 8'h00, 1'b0);
      wait_result(8'h00, 1'b0, 8'hFF, 1'b1, -1);
      idle_after();

      // Stray start at RUN cycle 3 must be ignored.
      launch(8'h10, 8'h20, 1'b0);
      wait_result(8'h30, 1'b0, 8'h00, 1'b0, 2);
      idle_after();

      // Back-to-back: start held during the done cycle.
      launch(8'h01, 8'h02, 1'b0);
      wait_result(8'h03, 1'b0, 8'h30, 1'b0, -1);
      drive(8'h12, 8'h34, 1'b0);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_done", 32'(done), 32'd0);
      wait_result(8'h46, 1'b0, 8'h03, 1'b0, -1);
      idle_after();

      // Asynchronous reset at RUN cycle 4.
      launch(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int dp;
         dp = 0;
         repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dp++;
         end
         check("abort_no_done", 32'(dp), 32'd0);
      end

      launch(8'h01, 8'h02, 1'b0);
      wait_result(8'h03, 1'b0, 8'h00, 1'b0, -1);
      idle_after();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
